evm_ballot_unit: RTL and testbench
==================================

# evm_ballot_unit

Voter-facing front end that sits directly upstream of the EVM controller. It conditions the raw officer button and the three candidate buttons through synchronisers and debouncers. It issues one `candidate_ready` pulse per ballot, then admits exactly one single-cycle `vote_candidate_N` pulse while the controller reports `voting_in_progress`. Multi-press, bounce, held buttons, presses outside a ballot and abandoned ballots are filtered out here, so the controller only ever sees clean, one-hot, one-cycle events.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronised cycles required before a debounced level changes (≥2).
- `CNT_W`, 5: width of the debounce and lockout counters; must hold `max(DEBOUNCE_CYCLES, LOCKOUT_CYCLES)`.
- `LOCKOUT_CYCLES`, 8: minimum cycles spent in LOCKOUT after a vote is issued (≥1).
- `WIDTH`, 7: width of `ballots_cast`.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `switch_on_evm`  in  1: when low, acts as a synchronous clear with the same effect as `rst`.
- `btn_officer_raw`  in  1: asynchronous raw officer "ready" button.
- `btn_candidate_raw`  in  3: asynchronous raw candidate buttons; bit0 is candidate 1.
- `voting_in_progress`  in  1: from the controller; high while it accepts a vote.
- `candidate_ready`  out  1: one-cycle pulse to the controller.
- `vote_candidate_1`, `vote_candidate_2`, `vote_candidate_3`  out  1 each: one-cycle, mutually exclusive vote pulses.
- `ballot_error`  out  1: one-cycle pulse when a multi-press is rejected.
- `ballot_timeout`  out  1: one-cycle pulse when an armed ballot is abandoned.
- `unit_busy`  out  1: high in every state except IDLE.
- `ballots_cast`  out  WIDTH: number of vote pulses issued; saturates at all-ones.

## Operation
- **Reset / clear.** On `rst=1` or `switch_on_evm=0`, all of the following go to 0 on the next edge:
  - all outputs;
  - synchroniser flops, debounced levels and counters;
  - the `seen_vip` flag.
  - The state goes to IDLE.
- **Synchroniser.** Each of the 4 raw inputs passes through 2 flops.
- **Debouncer (per input).**
  - While the synchronised value differs from the debounced level, the counter increments.
  - When the synchronised value equals the debounced level, the counter clears to 0.
  - On the cycle the counter would reach `DEBOUNCE_CYCLES`, the debounced level takes the new value and the counter clears.
- **Press event.** Debounced level is 1 and its value one cycle earlier was 0; evaluated combinationally.
- **IDLE**
  - An officer press event makes `candidate_ready` pulse and moves to ARMED.
  - `seen_vip` clears to 0.
  - Candidate presses are ignored.
- **ARMED**
  - `seen_vip` sets when `voting_in_progress=1`.
  - A candidate press event with `voting_in_progress=1` is then classified by the number of debounced candidate levels high:
    - exactly 1: pulse the matching `vote_candidate_N`, increment `ballots_cast`, go to LOCKOUT;
    - ≥2: pulse `ballot_error` and stay in ARMED.
  - A candidate press with `voting_in_progress=0` is ignored.
  - If `seen_vip=1` and `voting_in_progress=0` (the controller timed out), pulse `ballot_timeout` and go to IDLE. This check has priority over candidate presses in the same cycle.
  - Officer presses are ignored.
- **LOCKOUT**
  - The lockout counter counts up from 0.
  - The state leaves to IDLE when the counter is ≥ `LOCKOUT_CYCLES-1` and all 3 debounced candidate levels are 0; otherwise it waits indefinitely.
  - All presses are ignored.
  - The counter clears on exit.
- **Pulse exclusivity.** At most one of `candidate_ready`, `vote_candidate_*`, `ballot_error` and `ballot_timeout` is high in any cycle.
- **ballots_cast** is held at 2^WIDTH−1 once reached; further votes are still issued.

## Timing
- All outputs are registered. Every pulse is exactly 1 cycle wide.
- **Latency.** Raw input first sampled high at edge k, held:
  - debounced level rises at edge k+1+`DEBOUNCE_CYCLES`;
  - output pulse is high from edge k+2+`DEBOUNCE_CYCLES` to the following edge.
- **Bounce.** Any synchronised glitch shorter than `DEBOUNCE_CYCLES` cycles produces no event.
- **Held buttons.** A button held across states produces only its single rising event. A vote needs a release plus a new press.
- **Minimum ballot-to-ballot spacing** is `LOCKOUT_CYCLES` + 1 cycles after the vote pulse.
- **Reset mid-operation.** Any pulse scheduled for the next edge is suppressed. The unit is in IDLE after that edge.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and `LOCKOUT_CYCLES=8`.
- **Normal ballot.** Officer raw high at edge 10 → `candidate_ready` high cycle 16 only. Drive `voting_in_progress=1` from cycle 17. Raw candidate 2 high at edge 30 → `vote_candidate_2` high cycle 36 only, `ballots_cast`=1, `unit_busy` low after lockout once released.
- **Bounce.** Officer raw toggles 1,0,1,0 every cycle, then stays 0 → no `candidate_ready`. A 3-cycle candidate glitch in ARMED → no vote.
- **Multi-press.** In ARMED with VIP=1, candidates 1 and 3 pressed on the same edge → `ballot_error` one cycle, no vote, stays in ARMED. Release both, press 1 → `vote_candidate_1`.
- **Abandoned ballot.** VIP 1→0 with no press → `ballot_timeout` one cycle, state IDLE, `ballots_cast` unchanged.
- **Lockout/held.** Candidate 1 held through 40 cycles after a vote → no second pulse, unit stays in LOCKOUT until release.
- **Clear/saturation.** `switch_on_evm=0` for one cycle while ARMED → all outputs 0, IDLE. After 130 ballots with `WIDTH=7` → `ballots_cast`=127.

Source files
------------

// File: rtl/evm_ballot_unit.sv
// rtl/evm_ballot_unit.sv - button conditioning and single-vote gating ahead of the EVM controller
// Synchronises and debounces officer/candidate buttons, then admits one clean vote per ballot.
module evm_ballot_unit #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5,
   parameter int LOCKOUT_CYCLES  = 8,
   parameter int WIDTH           = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             switch_on_evm,
   input  logic             btn_officer_raw,
   input  logic [2:0]       btn_candidate_raw,
   input  logic             voting_in_progress,
   output logic             candidate_ready,
   output logic             vote_candidate_1,
   output logic             vote_candidate_2,
   output logic             vote_candidate_3,
   output logic             ballot_error,
   output logic             ballot_timeout,
   output logic             unit_busy,
   output logic [WIDTH-1:0] ballots_cast
);

   typedef enum logic [1:0] {IDLE, ARMED, LOCKOUT} state_t;

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

   logic             clr;
   logic [3:0]       raw;
   logic [3:0]       sync1;
   logic [3:0]       sync2;
   logic [3:0]       deb;
   logic [3:0]       deb_d;
   logic [3:0]       press;
   logic [CNT_W-1:0] deb_cnt [4];
   logic [2:0]       cand_lvl;
   logic             multi;

   state_t           state;
   state_t           state_next;
   logic             seen_vip;
   logic             seen_vip_next;
   logic [CNT_W-1:0] lock_cnt;
   logic [CNT_W-1:0] lock_cnt_next;
   logic             ready_next;
   logic             err_next;
   logic             to_next;
   logic [2:0]       vote_next;

   assign clr      = rst | ~switch_on_evm;
   assign raw      = {btn_candidate_raw, btn_officer_raw};
   assign press    = deb & ~deb_d;
   assign cand_lvl = deb[3:1];
   assign multi    = (cand_lvl[0] & cand_lvl[1]) | (cand_lvl[0] & cand_lvl[2]) |
                     (cand_lvl[1] & cand_lvl[2]);

   // Bit 0 is the officer button, bits 3:1 are candidates 1..3.
   always_ff @(posedge clk) begin
      if (clr) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_d <= '0;
         for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         deb_d <= deb;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb[i]     <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      state_next    = state;
      seen_vip_next = seen_vip;
      lock_cnt_next = lock_cnt;
      ready_next    = 1'b0;
      err_next      = 1'b0;
      to_next       = 1'b0;
      vote_next     = '0;
      case (state)
         IDLE: begin
            seen_vip_next = 1'b0;
            if (press[0]) begin
               ready_next = 1'b1;
               state_next = ARMED;
            end
         end
         ARMED: begin
            // A controller that dropped VIP after raising it has abandoned the ballot.
            if (seen_vip && !voting_in_progress) begin
               to_next    = 1'b1;
               state_next = IDLE;
            end else if (voting_in_progress) begin
               seen_vip_next = 1'b1;
               if (|press[3:1]) begin
                  if (multi) begin
                     err_next = 1'b1;
                  end else begin
                     vote_next  = cand_lvl;
                     state_next = LOCKOUT;
                  end
               end
            end
         end
         LOCKOUT: begin
            if (lock_cnt >= LOCK_LAST && cand_lvl == 3'b000) begin
               state_next    = IDLE;
               lock_cnt_next = '0;
            end else if (lock_cnt < LOCK_LAST) begin
               lock_cnt_next = lock_cnt + CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state            <= IDLE;
         seen_vip         <= 1'b0;
         lock_cnt         <= '0;
         candidate_ready  <= 1'b0;
         vote_candidate_1 <= 1'b0;
         vote_candidate_2 <= 1'b0;
         vote_candidate_3 <= 1'b0;
         ballot_error     <= 1'b0;
         ballot_timeout   <= 1'b0;
         unit_busy        <= 1'b0;
         ballots_cast     <= '0;
      end else begin
         state            <= state_next;
         seen_vip         <= seen_vip_next;
         lock_cnt         <= lock_cnt_next;
         candidate_ready  <= ready_next;
         vote_candidate_1 <= vote_next[0];
         vote_candidate_2 <= vote_next[1];
         vote_candidate_3 <= vote_next[2];
         ballot_error     <= err_next;
         ballot_timeout   <= to_next;
         unit_busy        <= (state_next != IDLE);
         if ((|vote_next) && (ballots_cast != '1)) ballots_cast <= ballots_cast + WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_evm_ballot_unit.sv
// tb/tb_evm_ballot_unit.sv - directed, table-driven and randomized checks of evm_ballot_unit
// A rule-level model (sample history, edge timestamps, vote totals) is compared every cycle.
module tb_evm_ballot_unit;

   localparam int DEB   = 4;
   localparam int LOCK  = 8;
   localparam int WIDTH = 7;
   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             switch_on_evm;
   logic             btn_officer_raw;
   logic [2:0]       btn_candidate_raw;
   logic             voting_in_progress;
   logic             candidate_ready;
   logic             vote_candidate_1;
   logic             vote_candidate_2;
   logic             vote_candidate_3;
   logic             ballot_error;
   logic             ballot_timeout;
   logic             unit_busy;
   logic [WIDTH-1:0] ballots_cast;

   always #5 clk = ~clk;

   evm_ballot_unit #(
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W          (CNT_W),
      .LOCKOUT_CYCLES (LOCK),
      .WIDTH          (WIDTH)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .switch_on_evm     (switch_on_evm),
      .btn_officer_raw   (btn_officer_raw),
      .btn_candidate_raw (btn_candidate_raw),
      .voting_in_progress(voting_in_progress),
      .candidate_ready   (candidate_ready),
      .vote_candidate_1  (vote_candidate_1),
      .vote_candidate_2  (vote_candidate_2),
      .vote_candidate_3  (vote_candidate_3),
      .ballot_error      (ballot_error),
      .ballot_timeout    (ballot_timeout),
      .unit_busy         (unit_busy),
      .ballots_cast      (ballots_cast)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int cnt_ready, cnt_err, cnt_to;
   int cnt_vote [3];
   int ready_edge, vote_edge;

   typedef enum {M_IDLE, M_ARMED, M_LOCK} m_state_t;
   m_state_t    m_state = M_IDLE;
   logic [3:0]  m_s1 = '0, m_s2 = '0, m_lvl = '0, m_lvl_prev = '0;
   bit          m_hist [4][DEB];
   int          m_hlen [4];
   bit          m_seen = 1'b0;
   int          m_vote_edge = 0;
   int          m_total = 0;
   logic [13:0] m_out = '0;

   typedef struct {
      logic [2:0] cand;
      logic       vip;
      logic [2:0] exp_vote;
      int         exp_err;
      int         exp_to;
   } vec_t;
   vec_t tbl [8];

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // One clock edge of the rules: pulses come from pre-edge levels, then levels and synchronisers advance.
   task automatic model_step();
      logic [3:0] press;
      logic [3:0] lv;
      logic [2:0] e_vote;
      logic       e_ready, e_err, e_to;
      logic [6:0] cast;
      bit         all_opp;
      e_ready = 1'b0;
      e_err   = 1'b0;
      e_to    = 1'b0;
      e_vote  = 3'b000;
      if (rst || !switch_on_evm) begin
         m_state    = M_IDLE;
         m_s1       = '0;
         m_s2       = '0;
         m_lvl      = '0;
         m_lvl_prev = '0;
         m_seen     = 1'b0;
         m_total    = 0;
         for (int i = 0; i < 4; i++) m_hlen[i] = 0;
         m_out = '0;
         return;
      end
      lv    = m_lvl;
      press = m_lvl & ~m_lvl_prev;
      case (m_state)
         M_IDLE: begin
            m_seen = 1'b0;
            if (press[0]) begin
               e_ready = 1'b1;
               m_state = M_ARMED;
            end
         end
         M_ARMED: begin
            if (m_seen && !voting_in_progress) begin
               e_to    = 1'b1;
               m_state = M_IDLE;
            end else if (voting_in_progress) begin
               m_seen = 1'b1;
               if (press[3:1] != 3'b000) begin
                  if ($countones(lv[3:1]) == 1) begin
                     e_vote      = lv[3:1];
                     m_total     = m_total + 1;
                     m_vote_edge = cyc;
                     m_state     = M_LOCK;
                  end else begin
                     e_err = 1'b1;
                  end
               end
            end
         end
         default: begin
            if ((cyc - m_vote_edge) >= LOCK && lv[3:1] == 3'b000) m_state = M_IDLE;
         end
      endcase
      m_lvl_prev = m_lvl;
      for (int i = 0; i < 4; i++) begin
         for (int k = DEB - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
         m_hist[i][0] = m_s2[i];
         if (m_hlen[i] < DEB) m_hlen[i] = m_hlen[i] + 1;
         all_opp = (m_hlen[i] == DEB);
         for (int k = 0; k < DEB; k++) if (m_hist[i][k] == m_lvl[i]) all_opp = 1'b0;
         if (all_opp) m_lvl[i] = ~m_lvl[i];
      end
      m_s2  = m_s1;
      m_s1  = {btn_candidate_raw, btn_officer_raw};
      cast  = (m_total > 127) ? 7'h7f : 7'(m_total);
      m_out = {e_ready, e_vote, e_err, e_to, (m_state != M_IDLE), cast};
   endtask

   task automatic tick();
      logic [13:0] dut_out;
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      dut_out = {candidate_ready, vote_candidate_3, vote_candidate_2, vote_candidate_1,
                 ballot_error, ballot_timeout, unit_busy, ballots_cast};
      n_checks++;
      if (dut_out !== m_out) begin
         n_fail++;
         $display("FAIL cycle_match edge %0d: got %h, want %h", cyc, dut_out, m_out);
      end
      if (candidate_ready) begin cnt_ready++; ready_edge = cyc; end
      if (vote_candidate_1) cnt_vote[0]++;
      if (vote_candidate_2) begin cnt_vote[1]++; vote_edge = cyc; end
      if (vote_candidate_3) cnt_vote[2]++;
      if (ballot_error) cnt_err++;
      if (ballot_timeout) cnt_to++;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clr_counts();
      cnt_ready = 0;
      cnt_err   = 0;
      cnt_to    = 0;
      for (int i = 0; i < 3; i++) cnt_vote[i] = 0;
   endtask

   task automatic arm();
      btn_officer_raw = 1'b1;
      run(6);
      btn_officer_raw = 1'b0;
      run(8);
   endtask

   initial begin
      logic [2:0]       vm;
      logic [WIDTH-1:0] cast0;
      int               busy_mid;

      tbl[0] = '{3'b001, 1'b1, 3'b001, 0, 0};
      tbl[1] = '{3'b010, 1'b1, 3'b010, 0, 0};
      tbl[2] = '{3'b100, 1'b1, 3'b100, 0, 0};
      tbl[3] = '{3'b011, 1'b1, 3'b000, 1, 1};
      tbl[4] = '{3'b101, 1'b1, 3'b000, 1, 1};
      tbl[5] = '{3'b110, 1'b1, 3'b000, 1, 1};
      tbl[6] = '{3'b111, 1'b1, 3'b000, 1, 1};
      tbl[7] = '{3'b010, 1'b0, 3'b000, 0, 1};

      rst = 1'b1; switch_on_evm = 1'b1; btn_officer_raw = 1'b0;
      btn_candidate_raw = 3'b000; voting_in_progress = 1'b0;
      clr_counts();
      ready_edge = -1; vote_edge = -1; busy_mid = -1;
      run(3);
      check("reset_outputs", int'({candidate_ready, vote_candidate_3, vote_candidate_2, vote_candidate_1,
             ballot_error, ballot_timeout, unit_busy, ballots_cast}), 0);
      rst = 1'b0;

      // Normal ballot, edges numbered from here
      cyc = 0;
      clr_counts();
      for (int e = 1; e <= 60; e++) begin
         btn_officer_raw    = (e >= 10 && e < 20);
         voting_in_progress = (e >= 17);
         btn_candidate_raw  = (e >= 30 && e < 40) ? 3'b010 : 3'b000;
         tick();
         if (e == 44) busy_mid = int'(unit_busy);
      end
      check("normal_ready_count", cnt_ready, 1);
      check("normal_ready_edge", ready_edge, 16);
      check("normal_vote2_count", cnt_vote[1], 1);
      check("normal_vote2_edge", vote_edge, 36);
      check("normal_other_votes", cnt_vote[0] + cnt_vote[2], 0);
      check("normal_cast", int'(ballots_cast), 1);
      check("normal_busy_in_lockout", busy_mid, 1);
      check("normal_busy_after", int'(unit_busy), 0);
      voting_in_progress = 1'b0;
      run(2);

      // Officer bounce, then a short candidate glitch while armed
      clr_counts();
      btn_officer_raw = 1'b1; tick(); btn_officer_raw = 1'b0; tick();
      btn_officer_raw = 1'b1; tick(); btn_officer_raw = 1'b0; tick();
      run(20);
      check("bounce_no_ready", cnt_ready, 0);
      check("bounce_idle", int'(unit_busy), 0);
      arm();
      check("bounce_armed_ready", cnt_ready, 1);
      voting_in_progress = 1'b1;
      run(4);
      btn_candidate_raw = 3'b001; run(3);
      btn_candidate_raw = 3'b000; run(20);
      check("glitch_no_vote", cnt_vote[0] + cnt_vote[1] + cnt_vote[2], 0);
      check("glitch_still_armed", int'(unit_busy), 1);

      // Multi-press rejected, then a clean single press accepted
      clr_counts();
      btn_candidate_raw = 3'b101; run(8);
      btn_candidate_raw = 3'b000; run(10);
      check("multi_error", cnt_err, 1);
      check("multi_no_vote", cnt_vote[0] + cnt_vote[1] + cnt_vote[2], 0);
      check("multi_still_armed", int'(unit_busy), 1);
      btn_candidate_raw = 3'b001; run(8);
      btn_candidate_raw = 3'b000; run(20);
      check("multi_then_vote1", cnt_vote[0], 1);
      check("multi_then_idle", int'(unit_busy), 0);

      for (int r = 0; r < 8; r++) begin
         voting_in_progress = 1'b0;
         arm();
         clr_counts();
         cast0 = ballots_cast;
         voting_in_progress = tbl[r].vip; run(2);
         btn_candidate_raw = tbl[r].cand; run(8);
         btn_candidate_raw = 3'b000; run(20);
         voting_in_progress = 1'b1; run(2);
         voting_in_progress = 1'b0; run(6);
         vm = {cnt_vote[2] > 0, cnt_vote[1] > 0, cnt_vote[0] > 0};
         check($sformatf("tbl%0d_vote_mask", r), int'(vm), int'(tbl[r].exp_vote));
         check($sformatf("tbl%0d_vote_total", r), cnt_vote[0] + cnt_vote[1] + cnt_vote[2],
               $countones(tbl[r].exp_vote));
         check($sformatf("tbl%0d_error", r), cnt_err, tbl[r].exp_err);
         check($sformatf("tbl%0d_timeout", r), cnt_to, tbl[r].exp_to);
         check($sformatf("tbl%0d_cast_delta", r), int'(ballots_cast) - int'(cast0),
               $countones(tbl[r].exp_vote));
         check($sformatf("tbl%0d_idle", r), int'(unit_busy), 0);
      end

      // Held candidate through lockout
      arm();
      clr_counts();
      voting_in_progress = 1'b1; run(2);
      btn_candidate_raw = 3'b001; run(50);
      check("held_single_vote", cnt_vote[0], 1);
      check("held_in_lockout", int'(unit_busy), 1);
      btn_candidate_raw = 3'b000; run(12);
      check("held_released_idle", int'(unit_busy), 0);
      check("held_no_error", cnt_err, 0);

      // Power switch clear while armed
      voting_in_progress = 1'b0;
      arm();
      check("clear_pre_armed", int'(unit_busy), 1);
      switch_on_evm = 1'b0; tick();
      check("clear_outputs", int'({candidate_ready, vote_candidate_3, vote_candidate_2, vote_candidate_1,
             ballot_error, ballot_timeout, unit_busy, ballots_cast}), 0);
      switch_on_evm = 1'b1; run(3);
      check("clear_stays_idle", int'(unit_busy), 0);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 11) == 0) btn_officer_raw = ~btn_officer_raw;
         for (int b = 0; b < 3; b++)
            if ($urandom_range(0, 15) == 0) btn_candidate_raw[b] = ~btn_candidate_raw[b];
         if ($urandom_range(0, 39) == 0) voting_in_progress = ~voting_in_progress;
         rst           = ($urandom_range(0, 499) == 0);
         switch_on_evm = ($urandom_range(0, 699) != 0);
         tick();
      end

      // Saturation over 130 ballots
      rst = 1'b1; switch_on_evm = 1'b1; btn_officer_raw = 1'b0;
      btn_candidate_raw = 3'b000; voting_in_progress = 1'b0;
      run(2);
      rst = 1'b0;
      voting_in_progress = 1'b1;
      clr_counts();
      for (int b = 0; b < 130; b++) begin
         for (int t = 0; t < 30; t++) begin
            btn_officer_raw   = (t < 6);
            btn_candidate_raw = (t >= 8 && t < 14) ? 3'b001 : 3'b000;
            tick();
         end
      end
      check("sat_votes_issued", cnt_vote[0], 130);
      check("sat_cast", int'(ballots_cast), 127);
      check("sat_no_error", cnt_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
